// File: rtl/gpio_pad_seq.sv
// ---------------------------------------------------------------------------
// gpio_pad_seq
//
// Pad-control sequencer for the 32-pad GPIO pad ring. After reset the pads
// are held high-Z with power-up pulls for a fixed window. When the window
// ends, the pad controls load from software-written shadow registers.
// Changes to drive strength, slew or push-pull are made glitch-free: the
// output drivers of the pads whose bit actually changes are tristated for
// SETTLE_CYCLES before the new value is applied and for SETTLE_CYCLES after.
//
// Ports
//   clk_i, rst_i        clock; synchronous active-high reset
//   cfg_valid_i/ready_o config write handshake (accepted on valid && ready)
//   cfg_addr_i          shadow register select:
//                         0 OUT, 1 OE, 2 IE, 3 PU, 4 PD, 5 DRV0, 6 DRV1,
//                         7 DRV2, 8 SLEW, 9 PPEN; 10..15 are unmapped
//   cfg_wdata_i         write data, one bit per pad
//   cfg_err_o           one-cycle pulse after a write to an unmapped address
//   busy_o              high whenever the sequencer is not in ACTIVE
//   gpio_in_o           pad receive data, masked by the receiver enable
//   dq                  pad receive data from the pad ring
//   outi, enabq, enq, puq, pd, drv0/1/2, prg_slew, ppen,
//   pwrup_pull_en, pwrupzhl
//                       registered pad control vectors to the pad ring
//
// Optional feature macro: GPIO_PAD_SEQ_SYNC_EN
//   defined   -> dq goes through a 2-flop synchronizer; dq->gpio_in_o = 3 cycles
//   undefined -> single register stage; dq->gpio_in_o = 1 cycle
// ---------------------------------------------------------------------------
module gpio_pad_seq #(
    parameter int NPADS         = 32,
    parameter int PWRUP_CYCLES  = 64,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [3:0]       cfg_addr_i,
    input  logic [NPADS-1:0] cfg_wdata_i,
    output logic             cfg_err_o,
    output logic             busy_o,
    output logic [NPADS-1:0] gpio_in_o,
    input  logic [NPADS-1:0] dq,
    output logic [NPADS-1:0] outi,
    output logic [NPADS-1:0] enabq,
    output logic [NPADS-1:0] enq,
    output logic [NPADS-1:0] puq,
    output logic [NPADS-1:0] pd,
    output logic [NPADS-1:0] drv0,
    output logic [NPADS-1:0] drv1,
    output logic [NPADS-1:0] drv2,
    output logic [NPADS-1:0] prg_slew,
    output logic [NPADS-1:0] ppen,
    output logic [NPADS-1:0] pwrup_pull_en,
    output logic [NPADS-1:0] pwrupzhl
);

    localparam int NSHADOW = 10;
    localparam int SH_OUT  = 0;
    localparam int SH_OE   = 1;
    localparam int SH_IE   = 2;
    localparam int SH_PU   = 3;
    localparam int SH_PD   = 4;
    localparam int SH_DRV0 = 5;
    localparam int SH_DRV1 = 6;
    localparam int SH_DRV2 = 7;
    localparam int SH_SLEW = 8;
    localparam int SH_PPEN = 9;

    localparam logic [3:0]  ADDR_LAST_DIRECT = 4'(SH_PD);
    localparam logic [3:0]  ADDR_LAST_MAPPED = 4'(SH_PPEN);
    localparam logic [15:0] PWRUP_LAST       = 16'(PWRUP_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST      = 16'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_HIZ,
        ST_RELEASE,
        ST_ACTIVE,
        ST_QUIESCE,
        ST_RESTORE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [NPADS-1:0]  shadow_q [NSHADOW];
    logic [NPADS-1:0]  shadow_d [NSHADOW];
    logic [NPADS-1:0]  pend_q, pend_d;
    logic [3:0]        pend_addr_q, pend_addr_d;
    logic [NPADS-1:0]  mask_q, mask_d;

    logic              cfg_ready_q, cfg_ready_d;
    logic              cfg_err_q, cfg_err_d;
    logic              busy_q, busy_d;
    logic [NPADS-1:0]  gpio_in_q, gpio_in_d;
    logic [NPADS-1:0]  outi_q, outi_d;
    logic [NPADS-1:0]  enabq_q, enabq_d;
    logic [NPADS-1:0]  enq_q, enq_d;
    logic [NPADS-1:0]  puq_q, puq_d;
    logic [NPADS-1:0]  pd_q, pd_d;
    logic [NPADS-1:0]  drv0_q, drv0_d;
    logic [NPADS-1:0]  drv1_q, drv1_d;
    logic [NPADS-1:0]  drv2_q, drv2_d;
    logic [NPADS-1:0]  prg_slew_q, prg_slew_d;
    logic [NPADS-1:0]  ppen_q, ppen_d;
    logic [NPADS-1:0]  pwrup_pull_en_q, pwrup_pull_en_d;
    logic [NPADS-1:0]  pwrupzhl_q, pwrupzhl_d;

    logic              commit_en;
    logic [3:0]        commit_addr;
    logic [NPADS-1:0]  commit_data;
    logic [NPADS-1:0]  cur_bits;
    logic [NPADS-1:0]  force_mask;
    logic [NPADS-1:0]  dq_s;

    // Receive path. The optional synchronizer sits in front of the same
    // final masked register, so only the latency changes between builds.
`ifdef GPIO_PAD_SEQ_SYNC_EN
    logic [NPADS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= dq;
            sync2_q <= sync1_q;
        end
    end

    assign dq_s = sync2_q;
`else
    assign dq_s = dq;
`endif

    // Next-state logic. All pad outputs are computed from the next state and
    // next shadow contents, so each registered output changes on the same
    // edge as the state/shadow update that causes it.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        mask_d      = mask_q;
        cfg_err_d   = 1'b0;
        commit_en   = 1'b0;
        commit_addr = '0;
        commit_data = '0;
        cur_bits    = '0;

        for (int i = 0; i < NSHADOW; i++) begin
            if (cfg_addr_i == 4'(i)) begin
                cur_bits = shadow_q[i];
            end
        end

        case (state_q)
            ST_HIZ: begin
                if (cnt_q == PWRUP_LAST) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (cfg_valid_i && cfg_ready_q) begin
                    if (cfg_addr_i <= ADDR_LAST_DIRECT) begin
                        commit_en   = 1'b1;
                        commit_addr = cfg_addr_i;
                        commit_data = cfg_wdata_i;
                    end else if (cfg_addr_i <= ADDR_LAST_MAPPED) begin
                        // Only pads whose bit flips need their driver
                        // tristated; an identical write commits at once.
                        if ((cfg_wdata_i ^ cur_bits) != '0) begin
                            pend_d      = cfg_wdata_i;
                            pend_addr_d = cfg_addr_i;
                            mask_d      = cfg_wdata_i ^ cur_bits;
                            state_d     = ST_QUIESCE;
                            cnt_d       = '0;
                        end else begin
                            commit_en   = 1'b1;
                            commit_addr = cfg_addr_i;
                            commit_data = cfg_wdata_i;
                        end
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_QUIESCE: begin
                if (cnt_q == SETTLE_LAST) begin
                    commit_en   = 1'b1;
                    commit_addr = pend_addr_q;
                    commit_data = pend_q;
                    state_d     = ST_RESTORE;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESTORE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                    mask_d  = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_HIZ;
                cnt_d   = '0;
            end
        endcase

        for (int i = 0; i < NSHADOW; i++) begin
            if (commit_en && (commit_addr == 4'(i))) begin
                shadow_d[i] = commit_data;
            end
        end

        force_mask = ((state_d == ST_QUIESCE) || (state_d == ST_RESTORE)) ? mask_d : '0;

        if (state_d == ST_HIZ) begin
            outi_d          = '0;
            enabq_d         = '1;
            enq_d           = '1;
            puq_d           = '1;
            pd_d            = '0;
            drv0_d          = '0;
            drv1_d          = '0;
            drv2_d          = '0;
            prg_slew_d      = '0;
            ppen_d          = '0;
            pwrup_pull_en_d = '1;
            pwrupzhl_d      = '1;
        end else begin
            outi_d          = shadow_d[SH_OUT];
            enabq_d         = ~shadow_d[SH_OE] | force_mask;
            enq_d           = ~shadow_d[SH_IE];
            puq_d           = ~shadow_d[SH_PU];
            pd_d            = shadow_d[SH_PD];
            drv0_d          = shadow_d[SH_DRV0];
            drv1_d          = shadow_d[SH_DRV1];
            drv2_d          = shadow_d[SH_DRV2];
            prg_slew_d      = shadow_d[SH_SLEW];
            ppen_d          = shadow_d[SH_PPEN];
            pwrup_pull_en_d = '0;
            pwrupzhl_d      = '0;
        end

        cfg_ready_d = (state_d == ST_ACTIVE);
        busy_d      = (state_d != ST_ACTIVE);
        gpio_in_d   = dq_s & ~enq_q;
    end

    // State, shadow and output registers. Reset also drops any pending
    // drive/slew/ppen change that was waiting in QUIESCE or RESTORE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_HIZ;
            cnt_q       <= '0;
            for (int i = 0; i < NSHADOW; i++) begin
                shadow_q[i] <= '0;
            end
            pend_q          <= '0;
            pend_addr_q     <= '0;
            mask_q          <= '0;
            cfg_ready_q     <= 1'b0;
            cfg_err_q       <= 1'b0;
            busy_q          <= 1'b1;
            gpio_in_q       <= '0;
            outi_q          <= '0;
            enabq_q         <= '1;
            enq_q           <= '1;
            puq_q           <= '1;
            pd_q            <= '0;
            drv0_q          <= '0;
            drv1_q          <= '0;
            drv2_q          <= '0;
            prg_slew_q      <= '0;
            ppen_q          <= '0;
            pwrup_pull_en_q <= '1;
            pwrupzhl_q      <= '1;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            shadow_q        <= shadow_d;
            pend_q          <= pend_d;
            pend_addr_q     <= pend_addr_d;
            mask_q          <= mask_d;
            cfg_ready_q     <= cfg_ready_d;
            cfg_err_q       <= cfg_err_d;
            busy_q          <= busy_d;
            gpio_in_q       <= gpio_in_d;
            outi_q          <= outi_d;
            enabq_q         <= enabq_d;
            enq_q           <= enq_d;
            puq_q           <= puq_d;
            pd_q            <= pd_d;
            drv0_q          <= drv0_d;
            drv1_q          <= drv1_d;
            drv2_q          <= drv2_d;
            prg_slew_q      <= prg_slew_d;
            ppen_q          <= ppen_d;
            pwrup_pull_en_q <= pwrup_pull_en_d;
            pwrupzhl_q      <= pwrupzhl_d;
        end
    end

    assign cfg_ready_o   = cfg_ready_q;
    assign cfg_err_o     = cfg_err_q;
    assign busy_o        = busy_q;
    assign gpio_in_o     = gpio_in_q;
    assign outi          = outi_q;
    assign enabq         = enabq_q;
    assign enq           = enq_q;
    assign puq           = puq_q;
    assign pd            = pd_q;
    assign drv0          = drv0_q;
    assign drv1          = drv1_q;
    assign drv2          = drv2_q;
    assign prg_slew      = prg_slew_q;
    assign ppen          = ppen_q;
    assign pwrup_pull_en = pwrup_pull_en_q;
    assign pwrupzhl      = pwrupzhl_q;

endmodule

// File: tb/tb_gpio_pad_seq.sv
// ---------------------------------------------------------------------------
// tb_gpio_pad_seq
//
// Directed and randomized bench for gpio_pad_seq. A small model keeps the
// ten shadow registers as plain values plus the set of pads currently being
// held tristated. Expected pad outputs are derived from those values using
// the documented timeline of each sequence.
// ---------------------------------------------------------------------------
module tb_gpio_pad_seq;

    localparam int NPADS  = 32;
    localparam int PWRUP  = 64;
    localparam int SETTLE = 4;
`ifdef GPIO_PAD_SEQ_SYNC_EN
    localparam int IN_LAT = 3;
`else
    localparam int IN_LAT = 1;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [3:0]       cfg_addr_i;
    logic [NPADS-1:0] cfg_wdata_i;
    logic             cfg_err_o;
    logic             busy_o;
    logic [NPADS-1:0] gpio_in_o;
    logic [NPADS-1:0] dq;
    logic [NPADS-1:0] outi, enabq, enq, puq, pd, drv0, drv1, drv2;
    logic [NPADS-1:0] prg_slew, ppen, pwrup_pull_en, pwrupzhl;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_sh [10];
    logic [31:0] m_force;

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    gpio_pad_seq #(
        .NPADS        (NPADS),
        .PWRUP_CYCLES (PWRUP),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_err_o    (cfg_err_o),
        .busy_o       (busy_o),
        .gpio_in_o    (gpio_in_o),
        .dq           (dq),
        .outi         (outi),
        .enabq        (enabq),
        .enq          (enq),
        .puq          (puq),
        .pd           (pd),
        .drv0         (drv0),
        .drv1         (drv1),
        .drv2         (drv2),
        .prg_slew     (prg_slew),
        .ppen         (ppen),
        .pwrup_pull_en(pwrup_pull_en),
        .pwrupzhl     (pwrupzhl)
    );

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " pwrupzhl"}, pwrupzhl, 32'hFFFF_FFFF);
        checkOutput({tag, " pull_en"}, pwrup_pull_en, 32'hFFFF_FFFF);
        checkOutput({tag, " enabq"}, enabq, 32'hFFFF_FFFF);
        checkOutput({tag, " enq"}, enq, 32'hFFFF_FFFF);
        checkOutput({tag, " puq"}, puq, 32'hFFFF_FFFF);
        checkOutput({tag, " outi"}, outi, 32'h0);
        checkOutput({tag, " pd"}, pd, 32'h0);
        checkOutput({tag, " drv0"}, drv0, 32'h0);
        checkOutput({tag, " drv1"}, drv1, 32'h0);
        checkOutput({tag, " drv2"}, drv2, 32'h0);
        checkOutput({tag, " slew"}, prg_slew, 32'h0);
        checkOutput({tag, " ppen"}, ppen, 32'h0);
        checkOutput({tag, " gpio_in"}, gpio_in_o, 32'h0);
        checkOutput({tag, " ready"}, cfg_ready_o, 32'd0);
        checkOutput({tag, " err"}, cfg_err_o, 32'd0);
        checkOutput({tag, " busy"}, busy_o, 32'd1);
    endtask

    // Pad outputs after release follow the shadow values; enabq is also
    // held high on any pad in the current tristate set.
    task automatic checkActive(input string tag, input logic exp_ready, input logic exp_err);
        logic exp_busy;
        exp_busy = ~exp_ready;
        checkOutput({tag, " outi"}, outi, m_sh[0]);
        checkOutput({tag, " enabq"}, enabq, ~m_sh[1] | m_force);
        checkOutput({tag, " enq"}, enq, ~m_sh[2]);
        checkOutput({tag, " puq"}, puq, ~m_sh[3]);
        checkOutput({tag, " pd"}, pd, m_sh[4]);
        checkOutput({tag, " drv0"}, drv0, m_sh[5]);
        checkOutput({tag, " drv1"}, drv1, m_sh[6]);
        checkOutput({tag, " drv2"}, drv2, m_sh[7]);
        checkOutput({tag, " slew"}, prg_slew, m_sh[8]);
        checkOutput({tag, " ppen"}, ppen, m_sh[9]);
        checkOutput({tag, " pwrupzhl"}, pwrupzhl, 32'h0);
        checkOutput({tag, " pull_en"}, pwrup_pull_en, 32'h0);
        checkOutput({tag, " ready"}, cfg_ready_o, 32'(exp_ready));
        checkOutput({tag, " busy"}, busy_o, 32'(exp_busy));
        checkOutput({tag, " err"}, cfg_err_o, 32'(exp_err));
    endtask

    // Presents one write and returns #1 after the edge that accepts it.
    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
        int n;
        cfg_addr_i  = addr;
        cfg_wdata_i = data;
        cfg_valid_i = 1'b1;
        n = 0;
        while (cfg_ready_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("ready before write", cfg_ready_o, 32'd1);
        tick();
        cfg_valid_i = 1'b0;
    endtask

    // Called #1 after the last edge with rst_i high: pads stay high-Z for
    // PWRUP cycles, then one RELEASE cycle, then the port becomes ready.
    // Writes presented during the window must be ignored.
    task automatic powerUp(input string tag);
        for (int i = 0; i < 10; i++) m_sh[i] = '0;
        m_force = '0;
        checkReset({tag, " reset"});
        rst_i       = 1'b0;
        cfg_valid_i = 1'b1;
        cfg_addr_i  = 4'd0;
        cfg_wdata_i = $urandom;
        for (int i = 1; i < PWRUP; i++) begin
            dq = $urandom;
            if (i == PWRUP - 4) cfg_valid_i = 1'b0;
            tick();
            checkOutput({tag, " hiz pwrupzhl"}, pwrupzhl, 32'hFFFF_FFFF);
            checkOutput({tag, " hiz pull_en"}, pwrup_pull_en, 32'hFFFF_FFFF);
            checkOutput({tag, " hiz ready"}, cfg_ready_o, 32'd0);
            checkOutput({tag, " hiz gpio_in"}, gpio_in_o, 32'h0);
        end
        tick();
        checkActive({tag, " release"}, 1'b0, 1'b0);
        checkOutput({tag, " release enabq"}, enabq, 32'hFFFF_FFFF);
        tick();
        checkActive({tag, " active"}, 1'b1, 1'b0);
    endtask

    // Drive/slew/ppen write: changed pads tristated for 2*SETTLE cycles,
    // new value visible after SETTLE cycles; an identical write is immediate.
    task automatic driveChange(input string tag, input logic [3:0] addr, input logic [31:0] data);
        logic [31:0] mask;
        mask = data ^ m_sh[addr];
        applyStimulus(addr, data);
        if (mask != 0) begin
            m_force = mask;
            for (int k = 1; k <= 2 * SETTLE; k++) begin
                if (k > SETTLE) m_sh[addr] = data;
                checkActive($sformatf("%s cyc%0d", tag, k), 1'b0, 1'b0);
                tick();
            end
            m_force = '0;
            checkActive({tag, " done"}, 1'b1, 1'b0);
        end else begin
            checkActive({tag, " nochange"}, 1'b1, 1'b0);
            tick();
            checkActive({tag, " nochange+1"}, 1'b1, 1'b0);
        end
    endtask

    initial begin
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] prev_dq;

        rst_i       = 1'b1;
        cfg_valid_i = 1'b0;
        cfg_addr_i  = '0;
        cfg_wdata_i = '0;
        dq          = '0;
        m_force     = '0;
        tick();
        tick();
        powerUp("pwrup");

        // Direct writes: one cycle from acceptance to pad.
        applyStimulus(4'd1, 32'h0000_00FF);
        m_sh[1] = 32'h0000_00FF;
        checkOutput("oe enabq", enabq, 32'hFFFF_FF00);
        applyStimulus(4'd0, 32'h0000_00A5);
        m_sh[0] = 32'h0000_00A5;
        checkOutput("out outi", outi, 32'h0000_00A5);
        checkActive("out", 1'b1, 1'b0);

        // DRV1 change with OE=0xFF: pads 0-3 tristated, 4-7 keep driving.
        driveChange("drv1", 4'd6, 32'h0000_000F);
        checkOutput("drv1 final", drv1, 32'h0000_000F);

        // DRV0 rewritten with its current value: no quiesce.
        driveChange("drv0 same", 4'd5, 32'h0);

        // Bad address: error pulse only.
        applyStimulus(4'd12, 32'hDEAD_BEEF);
        checkActive("badaddr", 1'b1, 1'b1);
        tick();
        checkActive("badaddr+1", 1'b1, 1'b0);

        // Random direct writes.
        for (int i = 0; i < 8; i++) begin
            a = 4'($urandom_range(0, 4));
            d = $urandom;
            applyStimulus(a, d);
            m_sh[a] = d;
            checkActive($sformatf("rand direct %0d", i), 1'b1, 1'b0);
        end

        // Random drive/slew/ppen writes.
        for (int i = 0; i < 3; i++) begin
            a = 4'($urandom_range(5, 9));
            d = $urandom;
            driveChange($sformatf("rand drive %0d", i), a, d);
        end

        // Random unmapped writes.
        for (int i = 0; i < 2; i++) begin
            a = 4'($urandom_range(10, 15));
            applyStimulus(a, $urandom);
            checkActive($sformatf("rand bad %0d", i), 1'b1, 1'b1);
        end

        // Receive path: gpio_in = dq masked by enabled receivers, IN_LAT late.
        prev_dq = $urandom;
        dq = prev_dq;
        for (int i = 0; i <= IN_LAT; i++) tick();
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            dq = d;
            for (int t = 1; t <= IN_LAT; t++) begin
                tick();
                checkOutput($sformatf("gpio_in %0d t%0d", i, t), gpio_in_o,
                            (t >= IN_LAT) ? (d & m_sh[2]) : (prev_dq & m_sh[2]));
            end
            prev_dq = d;
        end

        // Reset in the second QUIESCE cycle discards the pending DRV1 value.
        d = m_sh[6] ^ 32'h0000_00F0;
        applyStimulus(4'd6, d);
        m_force = 32'h0000_00F0;
        checkActive("midq cyc1", 1'b0, 1'b0);
        tick();
        checkActive("midq cyc2", 1'b0, 1'b0);
        rst_i = 1'b1;
        tick();
        powerUp("midq");
        checkOutput("midq drv1 lost", drv1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
